// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file slave.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

  localparam int unsigned ACK_BIT_IDX = 8;
  localparam int unsigned RW_BIT_POS  = 0;

  // Bus-level encodings of the ninth bit
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_slave_regfile.sv
// Byte-wide register file: async reset to RST_VAL, synchronous write, combinational read.
module i2c_slave_regfile #(
  parameter int unsigned DEPTH   = 16,
  parameter logic [7:0]  RST_VAL = 8'h00,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [7:0]       i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [7:0]       o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= RST_VAL;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/i2c_slave_param_ctrl.sv
// I2C slave with pointer-addressed register file, oversampled on the system clock.
// Optional I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample majority filter after each synchroniser.
module i2c_slave_param_ctrl
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned DEPTH      = 16,
  parameter logic [7:0]  RST_VAL    = 8'h00,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe_out,
  output logic             busy_out,
  output logic             wr_strobe_out,
  output logic [PTR_W-1:0] wr_addr_out,
  output logic [7:0]       wr_data_out
);

  logic [1:0] r_scl_sync, r_sda_sync;
  logic       w_scl, w_sda;

  // Idle bus level is high, so synchronisers reset high to avoid false edges
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_in};
      r_sda_sync <= {r_sda_sync[0], sda_in};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_filt, r_sda_filt;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_filt <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
      r_sda_filt <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  logic r_scl_prev, r_sda_prev;
  logic r_rise_d, r_fall_d;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;

  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
  assign w_stop     = r_scl_prev & w_scl & ~r_sda_prev & w_sda;

  // Delayed edges: sample SDA and update the drive one clock after the detected SCL edge
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      r_rise_d   <= 1'b0;
      r_fall_d   <= 1'b0;
    end else begin
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      r_rise_d   <= w_scl_rise;
      r_fall_d   <= w_scl_fall;
    end
  end

  state_e           r_state;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [PTR_W-1:0] r_ptr;
  logic             r_rw;
  logic             r_mack;
  logic             r_sda_oe;
  logic             r_busy;
  logic             r_wr_strobe;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;
  logic [7:0]       w_rd_data;
  logic [PTR_W-1:0] w_ptr_next;
  logic             w_byte_done;

  assign w_ptr_next  = (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  assign w_byte_done = (r_bit_cnt == 4'(ACK_BIT_IDX));

  i2c_slave_regfile #(
    .DEPTH  (DEPTH),
    .RST_VAL(RST_VAL)
  ) u_regfile (
    .i_clk  (clock_in),
    .i_rst  (reset_in),
    .i_we   (r_wr_strobe),
    .i_waddr(r_wr_addr),
    .i_wdata(r_wr_data),
    .i_raddr(r_ptr),
    .o_rdata(w_rd_data)
  );

  // Protocol FSM; bus conditions override every state
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_mack      <= NACK;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state   <= ST_DEV_ADDR;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
      end else begin
        case (r_state)
          ST_DEV_ADDR: begin
            if (r_rise_d) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (r_fall_d && w_byte_done) begin
              if (r_shift[7:1] == SLAVE_ADDR) begin
                r_sda_oe <= ~ACK;
                r_busy   <= 1'b1;
                r_rw     <= r_shift[RW_BIT_POS];
                r_state  <= ST_DEV_ACK;
              end else begin
                r_sda_oe <= ~NACK;
                r_busy   <= 1'b0;
                r_state  <= ST_WAIT_STOP;
              end
            end
          end
          ST_DEV_ACK: begin
            if (r_fall_d) begin
              if (r_rw) begin
                r_shift   <= w_rd_data;
                r_sda_oe  <= ~w_rd_data[7];
                r_bit_cnt <= 4'd1;
                r_state   <= ST_RD_DATA;
              end else begin
                r_sda_oe  <= ~NACK;
                r_bit_cnt <= '0;
                r_state   <= ST_PTR;
              end
            end
          end
          ST_PTR: begin
            if (r_rise_d) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (r_fall_d && w_byte_done) begin
              if ({1'b0, r_shift} < 9'(DEPTH)) begin
                r_sda_oe <= ~ACK;
                r_ptr    <= r_shift[PTR_W-1:0];
                r_state  <= ST_PTR_ACK;
              end else begin
                r_sda_oe <= ~NACK;
                r_state  <= ST_WAIT_STOP;
              end
            end
          end
          ST_PTR_ACK, ST_WR_ACK: begin
            if (r_fall_d) begin
              r_sda_oe  <= ~NACK;
              r_bit_cnt <= '0;
              r_state   <= ST_WR_DATA;
            end
          end
          ST_WR_DATA: begin
            if (r_rise_d) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (r_fall_d && w_byte_done) begin
              r_sda_oe    <= ~ACK;
              r_wr_strobe <= 1'b1;
              r_wr_addr   <= r_ptr;
              r_wr_data   <= r_shift;
              r_ptr       <= w_ptr_next;
              r_state     <= ST_WR_ACK;
            end
          end
          ST_RD_DATA: begin
            if (r_fall_d) begin
              if (w_byte_done) begin
                r_sda_oe <= ~NACK;
                r_ptr    <= w_ptr_next;
                r_state  <= ST_RD_ACK;
              end else begin
                r_sda_oe  <= ~r_shift[6];
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (r_rise_d) begin
              r_mack <= w_sda;
            end else if (r_fall_d) begin
              if (r_mack == ACK) begin
                r_shift   <= w_rd_data;
                r_sda_oe  <= ~w_rd_data[7];
                r_bit_cnt <= 4'd1;
                r_state   <= ST_RD_DATA;
              end else begin
                r_state <= ST_WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe_out    = r_sda_oe;
  assign busy_out      = r_busy;
  assign wr_strobe_out = r_wr_strobe;
  assign wr_addr_out   = r_wr_addr;
  assign wr_data_out   = r_wr_data;

endmodule

// File: tb/tb_i2c_slave_param_ctrl.sv
// Bench for i2c_slave_param_ctrl: bit-banged I2C master against a register-file reference model.
`timescale 1ns/1ps
module tb_i2c_slave_param_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int Q = 8;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int GLITCH_STARTS = 0;
`else
  localparam int GLITCH_STARTS = 1;
`endif

  typedef logic [7:0] byte_q_t[$];

  logic       clock_in = 1'b0;
  logic       reset_in;
  logic       scl_m, sda_m, sda_line;
  logic       sda_oe_out, busy_out, wr_strobe_out;
  logic [3:0] wr_addr_out;
  logic [7:0] wr_data_out;

  assign sda_line = sda_m & ~sda_oe_out;

  i2c_slave_param_ctrl #(
    .SLAVE_ADDR(7'h50),
    .DEPTH     (DEPTH),
    .RST_VAL   (8'h00)
  ) dut (
    .clock_in     (clock_in),
    .reset_in     (reset_in),
    .scl_in       (scl_m),
    .sda_in       (sda_line),
    .sda_oe_out   (sda_oe_out),
    .busy_out     (busy_out),
    .wr_strobe_out(wr_strobe_out),
    .wr_addr_out  (wr_addr_out),
    .wr_data_out  (wr_data_out)
  );

  always #5 clock_in = ~clock_in;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] mregs [DEPTH];
  int mptr;
  int exp_q[$];
  int s_idx = 0;

  // Observations collected by the monitor only
  int got_q[$];
  int oe_cnt = 0;
  int start_cnt = 0;

  always @(negedge clock_in) begin
    if (wr_strobe_out) got_q.push_back(int'({wr_addr_out, wr_data_out}));
    if (sda_oe_out) oe_cnt++;
    if (dut.w_start) start_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clock_in);
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    wq(); sda_m = b;
    wq(); scl_m = 1'b1;
    wq(); r = sda_line;
    wq(); scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wq(); sda_m = 1'b1;
    wq(); scl_m = 1'b1;
    wq(); sda_m = 1'b0;
    wq(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(); sda_m = 1'b0;
    wq(); scl_m = 1'b1;
    wq(); sda_m = 1'b1;
    wq();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], r);
    xfer_bit(1'b1, ack);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic nack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      d[i] = r;
    end
    xfer_bit(nack, r);
  endtask

  task automatic model_wr(input logic [7:0] d);
    mregs[mptr] = d;
    exp_q.push_back(int'({4'(mptr), d}));
    mptr = (mptr + 1) % DEPTH;
  endtask

  task automatic check_strobes(input string tag);
    chk({tag, "_strobe_cnt"}, got_q.size(), exp_q.size());
    while (s_idx < exp_q.size() && s_idx < got_q.size()) begin
      chk({tag, "_strobe"}, got_q[s_idx], exp_q[s_idx]);
      s_idx++;
    end
  endtask

  task automatic do_write(input string tag, input int p, input byte_q_t d);
    logic ack;
    i2c_start();
    wr_byte(8'hA0, ack); chk({tag, "_addr_ack"}, ack, 0);
    wr_byte(8'(p), ack); chk({tag, "_ptr_ack"}, ack, 0);
    mptr = p;
    foreach (d[i]) begin
      wr_byte(d[i], ack); chk({tag, "_data_ack"}, ack, 0);
      model_wr(d[i]);
    end
    i2c_stop();
    wq();
    check_strobes(tag);
  endtask

  task automatic do_read(input string tag, input int n);
    logic ack;
    logic [7:0] d;
    i2c_start();
    wr_byte(8'hA1, ack); chk({tag, "_rd_addr_ack"}, ack, 0);
    for (int i = 0; i < n; i++) begin
      rd_byte(d, (i == n - 1));
      chk({tag, "_rd_data"}, d, mregs[mptr]);
      mptr = (mptr + 1) % DEPTH;
    end
    i2c_stop();
  endtask

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic [7:0] d;
    byte_q_t q;
    int p, n, s0;

    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;
    mptr = 0;
    reset_in = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(negedge clock_in);
    chk("rst_sda_oe", sda_oe_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_strobe", wr_strobe_out, 0);
    chk("rst_wr_addr", wr_addr_out, 0);
    chk("rst_wr_data", wr_data_out, 0);
    reset_in = 1'b0;
    repeat (5) @(negedge clock_in);

    // Basic write of two bytes at pointer 3
    q = '{8'h11, 8'h22};
    do_write("t1", 3, q);
    chk("t1_busy_after_stop", busy_out, 0);
    chk("t1_wr_addr_held", wr_addr_out, 4);
    chk("t1_wr_data_held", wr_data_out, 8'h22);

    // Pointer write, repeated START, 3-byte read
    i2c_start();
    wr_byte(8'hA0, ack); chk("t2_addr_ack", ack, 0);
    chk("t2_busy_set", busy_out, 1);
    wr_byte(8'h02, ack); chk("t2_ptr_ack", ack, 0);
    mptr = 2;
    i2c_start();
    wr_byte(8'hA1, ack); chk("t2_rd_addr_ack", ack, 0);
    for (int i = 0; i < 3; i++) begin
      rd_byte(d, (i == 2));
      chk("t2_rd_data", d, mregs[mptr]);
      mptr = (mptr + 1) % DEPTH;
    end
    wq();
    chk("t2_busy_wait_stop", busy_out, 1);
    i2c_stop();
    chk("t2_busy_after_stop", busy_out, 0);

    // Wrong device address
    s0 = oe_cnt;
    i2c_start();
    wr_byte(8'hA4, ack); chk("t3_no_ack", ack, 1);
    wr_byte(8'h03, ack); chk("t3_ignored_ack", ack, 1);
    i2c_stop();
    chk("t3_oe_never", oe_cnt - s0, 0);
    chk("t3_busy", busy_out, 0);
    check_strobes("t3");

    // Pointer wrap and out-of-range pointer
    q = '{8'hAA, 8'hBB};
    do_write("t4", 15, q);
    q = {};
    do_write("t4p", 15, q);
    do_read("t4", 2);
    i2c_start();
    wr_byte(8'hA0, ack); chk("t4_bad_addr_ack", ack, 0);
    wr_byte(8'h10, ack); chk("t4_bad_ptr_nack", ack, 1);
    wr_byte(8'h55, ack); chk("t4_after_nack", ack, 1);
    i2c_stop();
    check_strobes("t4_bad");
    do_read("t4_persist", 2);

    // Randomised write / pointer-only / read mix
    for (int it = 0; it < 8; it++) begin
      p = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 4);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      do_write("rnd_wr", p, q);
      if ($urandom_range(0, 1) == 1) begin
        q = {};
        do_write("rnd_ptr", $urandom_range(0, DEPTH - 1), q);
      end
      do_read("rnd", $urandom_range(1, 4));
    end

    // Glitch on SDA while SCL high
    s0 = start_cnt;
    @(negedge clock_in) sda_m = 1'b0;
    @(negedge clock_in) sda_m = 1'b1;
    repeat (20) @(negedge clock_in);
    chk("glitch_starts", start_cnt - s0, GLITCH_STARTS);
    chk("glitch_busy", busy_out, 0);

    // Async reset while the slave drives a read bit low
    q = '{8'h3C};
    do_write("t5", 5, q);
    q = {};
    do_write("t5p", 5, q);
    i2c_start();
    wr_byte(8'hA1, ack); chk("t5_rd_addr_ack", ack, 0);
    wq(); wq();
    chk("t5_oe_before_rst", sda_oe_out, 1);
    reset_in = 1'b1;
    #1;
    chk("t5_oe_after_rst", sda_oe_out, 0);
    chk("t5_busy_after_rst", busy_out, 0);
    chk("t5_wr_data_after_rst", wr_data_out, 0);
    repeat (3) @(negedge clock_in);
    reset_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;
    mptr = 0;
    wq(); scl_m = 1'b1;
    wq(); sda_m = 1'b1;
    wq();
    do_read("t5_after_rst", 4);
    q = '{8'h5A};
    do_write("t5_post", 7, q);
    do_read("t5_post", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
